// File: rtl/pc_unit.sv
`default_nettype none
// pc_unit: program counter for the multi-cycle MIPS datapath. It provides boot sequencing,
// four next-PC modes, a circular return-address stack, trap redirect with EPC capture, and a halt state.
module pc_unit #(
    parameter int unsigned      WIDTH         = 32,
    parameter logic [WIDTH-1:0] FIRST_ADDRESS = '0,
    parameter logic [WIDTH-1:0] PC_INC        = WIDTH'(4),
    parameter logic [WIDTH-1:0] EXC_VECTOR    = WIDTH'(32'h0000_0080),
    parameter logic [WIDTH-1:0] HALT_ADDRESS  = WIDTH'(32'h0000_007C),
    parameter int unsigned      ALIGN_BITS    = 2,
    parameter int unsigned      RAS_DEPTH     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             pc_load_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             push_i,
    input  logic             trap_req_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] epc_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic             misalign_o,
    output logic             ras_err_o,
    output logic             ras_empty_o,
    output logic             ras_full_o
);

    localparam int unsigned      PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned      CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [1:0]       MODE_ABS   = 2'b00;
    localparam logic [1:0]       MODE_REL   = 2'b01;
    localparam logic [1:0]       MODE_POP   = 2'b10;
    localparam logic [1:0]       MODE_SEQ   = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic             misalign_q;
    logic             ras_err_q;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W-1:0] top_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] nxt_pc;
    logic [WIDTH-1:0] ras_top;
    logic [PTR_W-1:0] wr_ptr;
    logic             active;
    logic             commit;
    logic             ras_empty;
    logic             ras_full;
    logic             pop_empty;
    logic             bad_align;
    logic             take;
    logic             do_push;
    logic             do_pop;
    logic             trap;

    assign seq_pc    = pc_q + PC_INC;
    assign ras_top   = ras_q[top_q];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        nxt_pc = seq_pc;
        case (mode_i)
            MODE_ABS: nxt_pc = target_i;
            MODE_REL: nxt_pc = seq_pc + target_i;
            MODE_POP: nxt_pc = ras_top;
            MODE_SEQ: nxt_pc = seq_pc;
            default:  nxt_pc = seq_pc;
        endcase
    end

    // An empty-stack pop outranks the alignment check because its target is meaningless.
    assign active    = (state_q == ST_RUN) && en_i;
    assign commit    = active && !trap_req_i && pc_load_i;
    assign pop_empty = commit && (mode_i == MODE_POP) && ras_empty;
    assign bad_align = commit && !pop_empty && ((nxt_pc & ALIGN_MASK) != '0);
    assign trap      = active && (trap_req_i || pop_empty || bad_align);
    assign take      = commit && !pop_empty && !bad_align;
    assign do_push   = take && push_i;
    assign do_pop    = take && (mode_i == MODE_POP);

    // A simultaneous pop and push rewrites the top slot in place, leaving the pointer and the count unchanged.
    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_ptr = top_q;
        if (do_push && !do_pop) begin
            top_d  = top_q + PTR_W'(1);
            wr_ptr = top_q + PTR_W'(1);
            if (!ras_full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop && !do_push) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_BOOT;
            pc_q       <= '0;
            epc_q      <= '0;
            misalign_q <= 1'b0;
            ras_err_q  <= 1'b0;
            top_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (en_i) begin
                        pc_q    <= FIRST_ADDRESS;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en_i) begin
                        if (trap) begin
                            epc_q <= pc_q;
                            pc_q  <= EXC_VECTOR;
                        end else if (take) begin
                            pc_q <= nxt_pc;
                            if (nxt_pc == HALT_ADDRESS) begin
                                state_q <= ST_HALT;
                            end
                        end
                        if (pop_empty) begin
                            ras_err_q <= 1'b1;
                        end
                        if (bad_align) begin
                            misalign_q <= 1'b1;
                        end
                        if (do_push) begin
                            ras_q[wr_ptr] <= seq_pc;
                        end
                        top_q <= top_d;
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pc_o        = pc_q;
    assign epc_o       = epc_q;
    assign state_o     = state_q;
    assign halted_o    = (state_q == ST_HALT);
    assign misalign_o  = misalign_q;
    assign ras_err_o   = ras_err_q;
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// tb_pc_unit: directed walk of the main scenarios followed by random traffic, both checked against a queue-based model.
module tb_pc_unit;

    localparam logic [31:0] FIRST = 32'h0;
    localparam logic [31:0] EXC   = 32'h80;
    localparam logic [31:0] HALTA = 32'h7C;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, pc_load, push, trap_req;
    logic [1:0]  mode;
    logic [31:0] target;
    logic [31:0] pc, epc;
    logic [1:0]  state;
    logic        halted, misalign, ras_err, ras_empty, ras_full;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model. m_ras[0] is the top of the stack.
    logic [31:0] m_pc, m_epc;
    int          m_st;
    logic        m_mis, m_rerr;
    logic [31:0] m_ras[$];

    pc_unit dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .pc_load_i   (pc_load),
        .mode_i      (mode),
        .target_i    (target),
        .push_i      (push),
        .trap_req_i  (trap_req),
        .pc_o        (pc),
        .epc_o       (epc),
        .state_o     (state),
        .halted_o    (halted),
        .misalign_o  (misalign),
        .ras_err_o   (ras_err),
        .ras_empty_o (ras_empty),
        .ras_full_o  (ras_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_epc = '0; m_st = 0; m_mis = 0; m_rerr = 0;
        m_ras.delete();
    endtask

    task automatic model_trap();
        m_epc = m_pc;
        m_pc  = EXC;
    endtask

    task automatic model_edge(input logic e, input logic ld, input logic [1:0] md,
                              input logic [31:0] tg, input logic ps, input logic tr);
        logic [31:0] seq, nxt;
        if (m_st == 0) begin
            if (e) begin m_pc = FIRST; m_st = 1; end
        end else if (m_st == 1 && e) begin
            seq = m_pc + 32'd4;
            if (tr) model_trap();
            else if (ld) begin
                if (md == 2'b10 && m_ras.size() == 0) begin
                    model_trap();
                    m_rerr = 1;
                end else begin
                    case (md)
                        2'b00:   nxt = tg;
                        2'b01:   nxt = seq + tg;
                        2'b10:   nxt = m_ras[0];
                        default: nxt = seq;
                    endcase
                    if (nxt % 4 != 0) begin
                        model_trap();
                        m_mis = 1;
                    end else begin
                        if (md == 2'b10) void'(m_ras.pop_front());
                        if (ps) begin
                            m_ras.push_front(seq);
                            if (m_ras.size() > DEPTH) void'(m_ras.pop_back());
                        end
                        m_pc = nxt;
                        if (nxt == HALTA) m_st = 2;
                    end
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".pc"},       pc,                32'(m_pc));
        check_eq({tag, ".epc"},      epc,               32'(m_epc));
        check_eq({tag, ".state"},    32'(state),        32'(m_st));
        check_eq({tag, ".halted"},   32'(halted),       32'(m_st == 2));
        check_eq({tag, ".misalign"}, 32'(misalign),     32'(m_mis));
        check_eq({tag, ".ras_err"},  32'(ras_err),      32'(m_rerr));
        check_eq({tag, ".empty"},    32'(ras_empty),    32'(m_ras.size() == 0));
        check_eq({tag, ".full"},     32'(ras_full),     32'(m_ras.size() == DEPTH));
    endtask

    // Drive one cycle of inputs, clock it, then compare one time unit after the edge.
    task automatic cyc(input string tag, input logic e, input logic ld, input logic [1:0] md,
                       input logic [31:0] tg, input logic ps, input logic tr);
        en = e; pc_load = ld; mode = md; target = tg; push = ps; trap_req = tr;
        @(posedge clk);
        model_edge(e, ld, md, tg, ps, tr);
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] tg;
        int          r;
        rst_n = 1'b0; en = 0; pc_load = 0; mode = 0; target = 0; push = 0; trap_req = 0;
        model_reset();
        #12;
        compare_all("reset");
        rst_n = 1'b1;

        // Boot sequence followed by a hold.
        for (int i = 0; i < 3; i++) cyc("boot", 1, 0, 2'b00, 32'h0, 0, 0);
        check_eq("boot_state", 32'(state), 32'h1);

        // Sequential, relative and absolute modes, including wrap-around.
        cyc("abs10", 1, 1, 2'b00, 32'h10, 0, 0);
        cyc("seq",   1, 1, 2'b11, 32'h0, 0, 0);
        check_eq("plan_seq", pc, 32'h14);
        cyc("rel",   1, 1, 2'b01, 32'hFFFF_FFF8, 0, 0);
        check_eq("plan_rel", pc, 32'h10);
        cyc("absF",  1, 1, 2'b00, 32'hFFFF_FFFC, 0, 0);
        cyc("wrap",  1, 1, 2'b11, 32'h0, 0, 0);
        check_eq("plan_wrap", pc, 32'h0);

        // Call/return pair, then stack overflow and drain.
        cyc("to20",  1, 1, 2'b00, 32'h20, 0, 0);
        cyc("call",  1, 1, 2'b00, 32'h40, 1, 0);
        check_eq("plan_call", pc, 32'h40);
        cyc("ret",   1, 1, 2'b10, 32'h0, 0, 0);
        check_eq("plan_ret", pc, 32'h24);
        for (int i = 0; i < 5; i++) cyc("push5", 1, 1, 2'b11, 32'h0, 1, 0);
        check_eq("plan_full", 32'(ras_full), 32'h1);
        for (int i = 0; i < 4; i++) cyc("pop4", 1, 1, 2'b10, 32'h0, 0, 0);
        check_eq("plan_pop4", pc, 32'h2C);

        // Trap sources: misaligned target, empty pop, external request.
        cyc("to30",  1, 1, 2'b00, 32'h30, 0, 0);
        cyc("mis",   1, 1, 2'b00, 32'h42, 0, 0);
        check_eq("plan_mis_epc", epc, 32'h30);
        cyc("popE",  1, 1, 2'b10, 32'h0, 0, 0);
        check_eq("plan_rerr", 32'(ras_err), 32'h1);
        cyc("to84",  1, 1, 2'b11, 32'h0, 0, 0);
        cyc("trap",  1, 1, 2'b11, 32'h0, 1, 1);
        check_eq("plan_trap_epc", epc, 32'h84);

        // Halt, ignored inputs while halted, then reset during a stall.
        cyc("halt",  1, 1, 2'b00, HALTA, 0, 0);
        check_eq("plan_halted", 32'(halted), 32'h1);
        cyc("hTrap", 1, 0, 2'b00, 32'h0, 0, 1);
        cyc("hLoad", 1, 1, 2'b00, 32'h100, 1, 0);
        cyc("stall", 0, 1, 2'b11, 32'h0, 0, 0);
        async_reset("midrst");

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if ((m_st == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                async_reset("rnd_rst");
            end
            r = $urandom_range(0, 99);
            if (r < 5)       tg = HALTA;
            else if (r < 15) tg = $urandom | 32'h1;
            else if (r < 55) tg = ($urandom_range(0, 63) << 2) - 32'd128;
            else             tg = $urandom & 32'hFFFF_FFFC;
            cyc("rnd", 1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 70),
                2'($urandom_range(0, 3)), tg, 1'($urandom_range(0, 99) < 30),
                1'($urandom_range(0, 99) < 6));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
